// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch and PC-sequencing block for the 16-bit MIPS-style core.
//   The unit runs a four-state sequence:
//     START  - one idle cycle after reset release
//     FETCH  - request the word at the current PC, wait for the memory
//     EXEC   - present the word to the decoder for one cycle, sample the
//              resolved control feedback and load the next PC
//     HALTED - parked until reset_n_pi
//
//   Optional build macro: FETCH_TAKEN_COUNT_EN
//     defined   - taken_count_po counts EXEC cycles that select a jump or a
//                 taken branch (saturating, cleared only by reset_n_pi)
//     undefined - taken_count_po is tied to zero and no counter is built
//
// Ports
//   clk_pi           clock, rising edge
//   reset_n_pi       asynchronous active-low reset
//   imem_addr_po     instruction memory word address (equals pc_po)
//   imem_req_po      fetch request, held until imem_rdy_pi
//   imem_rdy_pi      memory has imem_data_pi valid for the current request
//   imem_data_pi     fetched instruction word
//   instruction_po   instruction to decoder, held until the next capture
//   instr_valid_po   one-cycle execute strobe
//   pc_po            PC of instruction_po
//   branch_taken_pi  resolved branch decision from the branch unit
//   jump_pi          decoder jump
//   halt_cmd_pi      decoder halt
//   rst_cmd_pi       decoder soft reset command
//   immediate_pi     decoder immediate field
//   halted_po        core halted
//   taken_count_po   taken branch/jump counter (optional feature)

module fetch_unit #(
  parameter int                     PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk_pi,
  input  logic                reset_n_pi,
  output logic [PC_WIDTH-1:0] imem_addr_po,
  output logic                imem_req_po,
  input  logic                imem_rdy_pi,
  input  logic [15:0]         imem_data_pi,
  output logic [15:0]         instruction_po,
  output logic                instr_valid_po,
  output logic [PC_WIDTH-1:0] pc_po,
  input  logic                branch_taken_pi,
  input  logic                jump_pi,
  input  logic                halt_cmd_pi,
  input  logic                rst_cmd_pi,
  input  logic [11:0]         immediate_pi,
  output logic                halted_po,
  output logic [15:0]         taken_count_po
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic [15:0]         instr_reg;

  // Next-PC candidates. All arithmetic wraps naturally at PC_WIDTH bits.
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0] branch_target;

  assign pc_plus1      = pc_reg + PC_WIDTH'(1);
  // Jumps stay inside the 4K-word page of the instruction after the jump.
  assign jump_target   = {pc_plus1[PC_WIDTH-1:12], immediate_pi};
  // Branch offset is the low six immediate bits, sign extended (-32..+31).
  assign branch_offset = {{(PC_WIDTH-6){immediate_pi[5]}}, immediate_pi[5:0]};
  assign branch_target = pc_plus1 + branch_offset;

  // --------------------------------------------------------------------------
  // State, PC and instruction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state_reg <= ST_START;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Capture only while a request is actually outstanding; a ready seen in any
  // other state is ignored.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      instr_reg <= '0;
    end else if (state_reg == ST_FETCH && imem_rdy_pi) begin
      instr_reg <= imem_data_pi;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-PC logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      ST_START: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_rdy_pi) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Feedback resolved in strict priority: soft reset, halt, jump,
        // taken branch, sequential.
        if (rst_cmd_pi) begin
          pc_next    = RESET_PC;
          state_next = ST_FETCH;
        end else if (halt_cmd_pi) begin
          state_next = ST_HALTED;
        end else if (jump_pi) begin
          pc_next    = jump_target;
          state_next = ST_FETCH;
        end else if (branch_taken_pi) begin
          pc_next    = branch_target;
          state_next = ST_FETCH;
        end else begin
          pc_next    = pc_plus1;
          state_next = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_START;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr_po   = pc_reg;
  assign pc_po          = pc_reg;
  assign imem_req_po    = (state_reg == ST_FETCH);
  assign instr_valid_po = (state_reg == ST_EXEC);
  assign halted_po      = (state_reg == ST_HALTED);
  assign instruction_po = instr_reg;

`ifdef FETCH_TAKEN_COUNT_EN
  // A redirect counts only when it is the selected case, i.e. neither a soft
  // reset nor a halt outranks it in the same EXEC cycle.
  logic        take_sel;
  logic [15:0] taken_count_reg;

  assign take_sel = (state_reg == ST_EXEC) && !rst_cmd_pi && !halt_cmd_pi &&
                    (jump_pi || branch_taken_pi);

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      taken_count_reg <= '0;
    end else if (take_sel && taken_count_reg != 16'hFFFF) begin
      taken_count_reg <= taken_count_reg + 16'd1;
    end
  end

  assign taken_count_po = taken_count_reg;
`else
  assign taken_count_po = '0;
`endif

endmodule
